// File: rtl/peripheral_ahb4_pkg.sv
// Shared AHB4 peripheral definitions: bus widths and signal encodings.
package peripheral_ahb4_pkg;

    localparam int unsigned HADDR_SIZE = 32;
    localparam int unsigned HDATA_SIZE = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_ahb4_be_decode.sv
// Byte-enable and alignment decode for one AHB beat on a 32-bit bus.
module peripheral_ahb4_be_decode
    import peripheral_ahb4_pkg::*;
(
    input  logic [1:0] haddr,
    input  logic [2:0] hsize,
    output logic [3:0] be,
    output logic       err
);

    // Lane select per transfer size; misaligned or oversized beats flag err.
    always_comb begin
        be  = 4'b0000;
        err = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                be = 4'b0001 << haddr;
            end
            HSIZE_HWORD: begin
                be  = 4'b0011 << {haddr[1], 1'b0};
                err = haddr[0];
            end
            HSIZE_WORD: begin
                be  = 4'b1111;
                err = (haddr != 2'b00);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/peripheral_ahb4_mem_bridge.sv
// AHB4 slave to simple req/ack word memory bridge with error response.
module peripheral_ahb4_mem_bridge
    import peripheral_ahb4_pkg::*;
#(
    parameter int unsigned HADDR_SIZE    = peripheral_ahb4_pkg::HADDR_SIZE,
    parameter int unsigned HDATA_SIZE    = peripheral_ahb4_pkg::HDATA_SIZE,
    parameter int unsigned MEM_ADDR_SIZE = 10
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [HADDR_SIZE-1:0]    HADDR,
    input  logic [HDATA_SIZE-1:0]    HWDATA,
    output logic [HDATA_SIZE-1:0]    HRDATA,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic [1:0]               HTRANS,
    input  logic                     HMASTLOCK,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       addr_phase;
    logic       accept;
    logic [3:0] dec_be;
    logic       dec_err;
    logic       unused_inputs;

    // Burst, protection and lock carry no meaning for this memory.
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR};

    // A valid address phase offered to this slave.
    assign addr_phase = HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // Write data is passed straight through during the data phase.
    assign mem_wdata = 32'(HWDATA);

    peripheral_ahb4_be_decode u_be_decode (
        .haddr (HADDR[1:0]),
        .hsize (HSIZE),
        .be    (dec_be),
        .err   (dec_err)
    );

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded bus/memory handshake outputs.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        mem_req   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                accept  = addr_phase;
                state_d = accept ? (dec_err ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                accept  = addr_phase;
                state_d = accept ? (dec_err ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                mem_req   = 1'b1;
                if (mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transfer attributes captured at accept, held through the access.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_be   <= 4'b0000;
        end else if (accept) begin
            mem_we   <= HWRITE;
            mem_addr <= HADDR[MEM_ADDR_SIZE+1:2];
            mem_be   <= dec_be;
        end
    end

    // Read data register, loaded only on a read completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= '0;
        end else if ((state_q == ST_ACCESS) && mem_ack && !mem_we) begin
            HRDATA <= HDATA_SIZE'(mem_rdata);
        end
    end

endmodule

// File: tb/tb_peripheral_ahb4_mem_bridge.sv
// Self-checking bench for the AHB4 memory bridge against a transfer-level model.
module tb_peripheral_ahb4_mem_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        hready_block;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hrdata;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT & ~hready_block;

    peripheral_ahb4_mem_bridge dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transfer-level rules: lanes from byte offset, legal only if naturally aligned.
    function automatic void ref_decode(input logic [31:0] a, input int sz,
                                       output logic [3:0] be, output logic err);
        int off;
        off = int'(a % 4);
        err = (sz > 2) || ((a % (32'd1 << sz)) != 0);
        case (sz)
            0:       be = 4'(1 << off);
            1:       be = 4'(3 << (off & 2));
            2:       be = 4'hF;
            default: be = 4'h0;
        endcase
    endfunction

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // One AHB transfer; the address phase overlaps whatever cycle we are in.
    task automatic do_xfer(input logic [31:0] addr, input int sz, input logic wr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int ack_dly);
        logic [3:0] ebe;
        logic       eerr;
        ref_decode(addr, sz, ebe, eerr);
        HSEL   = 1'b1;
        HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        HADDR  = addr;
        HSIZE  = 3'(sz);
        HWRITE = wr;
        HBURST = 3'($urandom_range(0, 7));
        HPROT  = 4'($urandom_range(0, 15));
        tick();
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = 2'b00;
        HADDR  = $urandom;
        HSIZE  = 3'($urandom_range(0, 7));
        HWRITE = 1'($urandom_range(0, 1));
        HWDATA = wdata;
        if (eerr) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            check("err1_hreadyout", 32'(HREADYOUT), 0);
            check("err1_hresp", 32'(HRESP), 1);
            check("err1_mem_req", 32'(mem_req), 0);
            tick();
            mem_ack = 1'b0;
            check("err2_hreadyout", 32'(HREADYOUT), 1);
            check("err2_hresp", 32'(HRESP), 1);
            check("err_hrdata", HRDATA, exp_hrdata);
        end else begin
            for (int c = 1; c <= ack_dly; c++) begin
                check("acc_mem_req", 32'(mem_req), 1);
                check("acc_hreadyout", 32'(HREADYOUT), 0);
                check("acc_hresp", 32'(HRESP), 0);
                check("acc_mem_addr", 32'(mem_addr), (addr >> 2) & 32'h3FF);
                check("acc_mem_be", 32'(mem_be), 32'(ebe));
                check("acc_mem_we", 32'(mem_we), 32'(wr));
                if (wr) check("acc_mem_wdata", mem_wdata, wdata);
                check("acc_hrdata", HRDATA, exp_hrdata);
                if (c == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                tick();
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!wr) exp_hrdata = rdata;
            check("done_hreadyout", 32'(HREADYOUT), 1);
            check("done_hresp", 32'(HRESP), 0);
            check("done_mem_req", 32'(mem_req), 0);
            check("done_hrdata", HRDATA, exp_hrdata);
        end
    endtask

    // Bus cycles that must not start an access; stray acks must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin HSEL = 1'b1; HTRANS = 2'b00; end
                1: begin HSEL = 1'b1; HTRANS = 2'b01; end
                2: begin HSEL = 1'b0; HTRANS = 2'b10; end
                default: begin HSEL = 1'b0; HTRANS = 2'b11; end
            endcase
            HADDR     = $urandom;
            HSIZE     = 3'($urandom_range(0, 2));
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            check("idle_mem_req", 32'(mem_req), 0);
            check("idle_hreadyout", 32'(HREADYOUT), 1);
            check("idle_hresp", 32'(HRESP), 0);
            check("idle_hrdata", HRDATA, exp_hrdata);
        end
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sz;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = 3'b010; HBURST = '0; HPROT = '0; HTRANS = 2'b00; HMASTLOCK = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0; hready_block = 1'b0;
        exp_hrdata = '0;
        tick();
        tick();
        check("rst_hreadyout", 32'(HREADYOUT), 1);
        check("rst_hresp", 32'(HRESP), 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        HRESET = 1'b0;
        tick();

        // Directed cases from the feature list.
        do_xfer(32'h0000_0010, 2, 1'b1, 32'hDEADBEEF, 32'h0, 3);
        idle_cycles(1);
        do_xfer(32'h0000_0013, 0, 1'b0, 32'h0, 32'h11223344, 1);
        idle_cycles(1);
        do_xfer(32'h0000_0002, 2, 1'b0, 32'h0, 32'h0, 1);
        idle_cycles(1);
        do_xfer(32'h0000_0008, 2, 1'b1, 32'hA5A5_0001, 32'h0, 1);
        do_xfer(32'h0000_000C, 2, 1'b0, 32'h0, 32'hCAFE_F00D, 1);
        idle_cycles(4);

        // Selected but HREADY low: must not be accepted.
        hready_block = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HSIZE = 3'b010; HWRITE = 1'b1;
        tick();
        check("hready0_mem_req", 32'(mem_req), 0);
        check("hready0_hreadyout", 32'(HREADYOUT), 1);
        hready_block = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        check("hready0_after_req", 32'(mem_req), 0);

        // Randomized mix, back-to-back or separated by gaps.
        for (int t = 0; t < 60; t++) begin
            a  = $urandom;
            sz = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 7));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_xfer(a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(1);

        // Make HRDATA nonzero, then reset two cycles into an unacked access.
        do_xfer(32'h0000_0040, 2, 1'b0, 32'h0, 32'h1357_9BDF, 1);
        idle_cycles(1);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h44; HSIZE = 3'b010; HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        check("pre_rst_mem_req", 32'(mem_req), 1);
        tick();
        check("pre_rst_mem_req2", 32'(mem_req), 1);
        HRESET = 1'b1;
        #1;
        exp_hrdata = '0;
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_hreadyout", 32'(HREADYOUT), 1);
        check("midrst_hrdata", HRDATA, 0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        HRESET = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("late_ack_mem_req", 32'(mem_req), 0);
        check("late_ack_hreadyout", 32'(HREADYOUT), 1);
        check("late_ack_hrdata", HRDATA, 0);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
